// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO and sequencer feeding an 8-bit ALU, result via valid/ready
// Optional res_zero output is built when ALU_CMD_ZERO_FLAG_EN is defined.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [2:0] cmd_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_result,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [2:0] res_op,
`ifdef ALU_CMD_ZERO_FLAG_EN
    output logic       res_zero,
`endif
    output logic [7:0] res_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [10:0]    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic [3:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]     alu_op_q, alu_op_d;
    logic           res_valid_q, res_valid_d;
    logic [7:0]     res_data_q, res_data_d;
    logic [2:0]     res_op_q, res_op_d;
    logic [7:0]     res_count_q, res_count_d;
    logic           push, pop, fifo_nempty;
`ifdef ALU_CMD_ZERO_FLAG_EN
    logic           res_zero_q, res_zero_d;
    assign res_zero = res_zero_q;
`endif

    // Ready depends on the registered count only, so no combinational path from cmd_valid/res_ready.
    assign cmd_ready   = (count_q < (AW+1)'(DEPTH));
    assign fifo_nempty = (count_q != '0);
    assign push        = cmd_valid && cmd_ready;

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_op    = res_op_q;
    assign res_count = res_count_q;

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        res_count_d = res_count_q;
`ifdef ALU_CMD_ZERO_FLAG_EN
        res_zero_d  = res_zero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (fifo_nempty) begin
                    pop     = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_data_d  = alu_result;
                res_op_d    = alu_op_q;
                res_valid_d = 1'b1;
`ifdef ALU_CMD_ZERO_FLAG_EN
                res_zero_d  = (alu_result == 8'h00);
`endif
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    res_count_d = res_count_q + 8'd1;
                    if (fifo_nempty) begin
                        pop     = 1'b1;
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            {alu_a_d, alu_b_d, alu_op_d} = mem_q[rd_ptr_q];
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_a, cmd_b, cmd_op};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            res_count_q <= '0;
`ifdef ALU_CMD_ZERO_FLAG_EN
            res_zero_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
            res_count_q <= res_count_d;
`ifdef ALU_CMD_ZERO_FLAG_EN
            res_zero_q  <= res_zero_d;
`endif
        end
    end

endmodule
